// File: rtl/hazard_pkg.sv
// Shared constants and the scoreboard entry type for the hazard controller.
package hazard_pkg;

   localparam int REG_ADDR_W_DEF = 5;
   // Entries store rd at this width so any REG_ADDR_W up to 8 fits unchanged
   localparam int RD_MAX_W       = 8;
   localparam int LOAD_LAT_MAX   = 4;

   localparam logic [RD_MAX_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                valid;
      logic [RD_MAX_W-1:0] rd;
   } sb_entry_t;

endpackage

// File: rtl/load_scoreboard.sv
// Shift register of in-flight loads; entry 0 is the load now in EX.
// hit_o flags a read of a live, non-zero load destination.
module load_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int DEPTH      = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  shift_en_i,
   input  logic                  push_valid_i,
   input  logic [REG_ADDR_W-1:0] push_rd_i,
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [REG_ADDR_W-1:0] rt_i,
   input  logic                  rs_used_i,
   input  logic                  rt_used_i,
   output logic                  hit_o
);

   sb_entry_t           r_sb [DEPTH];
   logic [DEPTH-1:0]    w_hit;
   logic [RD_MAX_W-1:0] w_push_rd;
   logic [RD_MAX_W-1:0] w_rs;
   logic [RD_MAX_W-1:0] w_rt;

   assign w_push_rd = RD_MAX_W'(push_rd_i);
   assign w_rs      = RD_MAX_W'(rs_i);
   assign w_rt      = RD_MAX_W'(rt_i);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         if (gi == 0) begin : g_head
            // Entry 0 takes the load leaving ID, or a bubble
            always_ff @(posedge clk_i) begin
               if (rst_i) begin
                  r_sb[0] <= '0;
               end else if (shift_en_i) begin
                  r_sb[0].valid <= push_valid_i;
                  r_sb[0].rd    <= w_push_rd;
               end
            end
         end else begin : g_tail
            // Older entries age by one stage; the last one falls off
            always_ff @(posedge clk_i) begin
               if (rst_i) begin
                  r_sb[gi] <= '0;
               end else if (shift_en_i) begin
                  r_sb[gi] <= r_sb[gi-1];
               end
            end
         end

         assign w_hit[gi] = r_sb[gi].valid && (r_sb[gi].rd != ZERO_REG) &&
                            ((rs_used_i && (r_sb[gi].rd == w_rs)) ||
                             (rt_used_i && (r_sb[gi].rd == w_rt)));
      end
   endgenerate

   assign hit_o = |w_hit;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/stall controller: arbitrates dmem freeze, taken-branch flush and
// load-use stalls, and keeps saturating stall counters.
module hazard_ctrl_mc
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  id_rs_used_i,
   input  logic                  id_rt_used_i,
   input  logic                  id_mem_read_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  ex_branch_taken_i,
   input  logic                  dmem_busy_i,
   input  logic                  cnt_clr_i,
   output logic                  pc_write_o,
   output logic                  if_id_write_o,
   output logic                  bubble_o,
   output logic                  flush_o,
   output logic [CNT_W-1:0]      lu_stall_cnt_o,
   output logic [CNT_W-1:0]      mem_stall_cnt_o
);

   logic             w_sb_hit;
   logic             w_lu_hazard;
   logic             w_shift_en;
   logic             w_push_valid;
   logic             w_lu_inc;
   logic             w_pc_write;
   logic             w_if_id_write;
   logic             w_bubble;
   logic             w_flush;
   logic [CNT_W-1:0] r_lu_cnt;
   logic [CNT_W-1:0] r_mem_cnt;

   // A freeze holds the scoreboard so frozen cycles do not age a load
   assign w_shift_en   = ~dmem_busy_i;
   assign w_lu_hazard  = id_valid_i & w_sb_hit;
   // Only a load that actually advances out of ID is tracked
   assign w_push_valid = id_valid_i & id_mem_read_i & ~dmem_busy_i &
                         ~ex_branch_taken_i & ~w_lu_hazard;
   assign w_lu_inc     = ~dmem_busy_i & ~ex_branch_taken_i & w_lu_hazard;

   load_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W),
      .DEPTH      (LOAD_LAT)
   ) u_sb (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .shift_en_i   (w_shift_en),
      .push_valid_i (w_push_valid),
      .push_rd_i    (id_rd_i),
      .rs_i         (id_rs_i),
      .rt_i         (id_rt_i),
      .rs_used_i    (id_rs_used_i),
      .rt_used_i    (id_rt_used_i),
      .hit_o        (w_sb_hit)
   );

   // Priority: reset, freeze, branch flush, load-use stall, normal advance
   always_comb begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_bubble      = 1'b0;
      w_flush       = 1'b0;
      if (rst_i) begin
         w_pc_write    = 1'b0;
         w_if_id_write = 1'b0;
         w_bubble      = 1'b1;
      end else if (dmem_busy_i) begin
         w_pc_write    = 1'b0;
         w_if_id_write = 1'b0;
      end else if (ex_branch_taken_i) begin
         w_bubble      = 1'b1;
         w_flush       = 1'b1;
      end else if (w_lu_hazard) begin
         w_pc_write    = 1'b0;
         w_if_id_write = 1'b0;
         w_bubble      = 1'b1;
      end
   end

   assign pc_write_o    = w_pc_write;
   assign if_id_write_o = w_if_id_write;
   assign bubble_o      = w_bubble;
   assign flush_o       = w_flush;

   // Load-use bubble counter, saturating; clear beats increment
   always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clr_i) begin
         r_lu_cnt <= '0;
      end else if (w_lu_inc && !(&r_lu_cnt)) begin
         r_lu_cnt <= r_lu_cnt + 1'b1;
      end
   end

   // Data-memory freeze counter, saturating; clear beats increment
   always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clr_i) begin
         r_mem_cnt <= '0;
      end else if (dmem_busy_i && !(&r_mem_cnt)) begin
         r_mem_cnt <= r_mem_cnt + 1'b1;
      end
   end

   assign lu_stall_cnt_o  = r_lu_cnt;
   assign mem_stall_cnt_o = r_mem_cnt;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench: three instances (LOAD_LAT=1, LOAD_LAT=2, CNT_W=2) share
// one stimulus stream; each group resets first and checks the relevant one.
module tb_hazard_ctrl_mc;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_rs_used, id_rt_used, id_mem_read;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       br_taken, dmem_busy, cnt_clr;

   logic        pc1, ifid1, bub1, fl1;
   logic        pc2, ifid2, bub2, fl2;
   logic        pc3, ifid3, bub3, fl3;
   logic [15:0] lu1, mem1, lu2, mem2;
   logic [1:0]  lu3, mem3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_ctrl_mc #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
      .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
      .id_mem_read_i(id_mem_read), .id_rd_i(id_rd),
      .ex_branch_taken_i(br_taken), .dmem_busy_i(dmem_busy),
      .cnt_clr_i(cnt_clr), .pc_write_o(pc1), .if_id_write_o(ifid1),
      .bubble_o(bub1), .flush_o(fl1), .lu_stall_cnt_o(lu1),
      .mem_stall_cnt_o(mem1));

   hazard_ctrl_mc #(.REG_ADDR_W(5), .LOAD_LAT(2), .CNT_W(16)) u_l2 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
      .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
      .id_mem_read_i(id_mem_read), .id_rd_i(id_rd),
      .ex_branch_taken_i(br_taken), .dmem_busy_i(dmem_busy),
      .cnt_clr_i(cnt_clr), .pc_write_o(pc2), .if_id_write_o(ifid2),
      .bubble_o(bub2), .flush_o(fl2), .lu_stall_cnt_o(lu2),
      .mem_stall_cnt_o(mem2));

   hazard_ctrl_mc #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(2)) u_c2 (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs),
      .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
      .id_mem_read_i(id_mem_read), .id_rd_i(id_rd),
      .ex_branch_taken_i(br_taken), .dmem_busy_i(dmem_busy),
      .cnt_clr_i(cnt_clr), .pc_write_o(pc3), .if_id_write_o(ifid3),
      .bubble_o(bub3), .flush_o(fl3), .lu_stall_cnt_o(lu3),
      .mem_stall_cnt_o(mem3));

   // Output nibble order: {pc_write, if_id_write, bubble, flush}
   wire [3:0] o1 = {pc1, ifid1, bub1, fl1};
   wire [3:0] o2 = {pc2, ifid2, bub2, fl2};
   wire [3:0] o3 = {pc3, ifid3, bub3, fl3};

   localparam logic [3:0] O_RUN   = 4'b1100;
   localparam logic [3:0] O_STALL = 4'b0010;
   localparam logic [3:0] O_FRZ   = 4'b0000;
   localparam logic [3:0] O_FLUSH = 4'b1111;
   localparam logic [3:0] O_RST   = 4'b0010;

   task automatic check(input string tag, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, act, exp);
      end else begin
         $display("ok   %s: %0d", tag, act);
      end
   endtask

   // Advance one edge; inputs change 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Combinational outputs are sampled 1ns after inputs change
   task automatic settle();
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
      id_mem_read = 0; id_rd = 0; br_taken = 0; dmem_busy = 0; cnt_clr = 0;
   endtask

   task automatic lw(input logic [4:0] rd);
      idle();
      id_valid = 1; id_mem_read = 1; id_rd = rd; id_rs = 5'd29;
      id_rs_used = 1;
   endtask

   task automatic alu(input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu);
      idle();
      id_valid = 1; id_rs = rs; id_rs_used = rsu; id_rt = rt;
      id_rt_used = rtu; id_rd = 5'd10;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      step();
      rst = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      #2;
      settle();
      check("rst_outs", o1, O_RST);
      step();
      check("rst_lu_cnt", lu1, 0);
      check("rst_mem_cnt", mem1, 0);
      rst = 0; settle();
      check("idle_run", o1, O_RUN);
      step();

      // Dependent add right after lw $8
      do_reset();
      lw(5'd8); settle();
      check("l1_lw_adv", o1, O_RUN);
      step();
      alu(5'd8, 1, 5'd9, 1); settle();
      check("l1_use_stall", o1, O_STALL);
      check("l2_use_stall1", o2, O_STALL);
      step(); settle();
      check("l1_use_resume", o1, O_RUN);
      check("l1_lu_cnt", lu1, 1);
      check("l2_use_stall2", o2, O_STALL);
      step(); settle();
      check("l2_use_resume", o2, O_RUN);
      check("l2_lu_cnt", lu2, 2);
      step();

      // LOAD_LAT=2, one independent instruction between lw and user
      do_reset();
      lw(5'd8); step();
      alu(5'd1, 1, 5'd2, 1); settle();
      check("l2_indep_run", o2, O_RUN);
      step();
      alu(5'd8, 1, 5'd0, 0); settle();
      check("l2_d2_stall", o2, O_STALL);
      step(); settle();
      check("l2_d2_resume", o2, O_RUN);
      check("l2_d2_cnt", lu2, 1);
      step();

      // $0 never hazards; unused rt never hazards
      do_reset();
      lw(5'd0); step();
      alu(5'd0, 1, 5'd0, 1); settle();
      check("r0_l1", o1, O_RUN);
      check("r0_l2", o2, O_RUN);
      step();
      lw(5'd8); step();
      alu(5'd1, 1, 5'd8, 0); settle();
      check("rt_unused_l1", o1, O_RUN);
      check("rt_unused_l2", o2, O_RUN);
      step();
      check("nohaz_cnt_l1", lu1, 0);
      check("nohaz_cnt_l2", lu2, 0);

      // Freeze during a pending load-use
      do_reset();
      lw(5'd8); step();
      alu(5'd8, 1, 5'd3, 1);
      dmem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("frz_%0d", i), o1, O_FRZ);
         step();
      end
      dmem_busy = 0; settle();
      check("frz_then_stall", o1, O_STALL);
      check("frz_mem_cnt", mem1, 3);
      check("frz_lu_cnt0", lu1, 0);
      step(); settle();
      check("frz_resume", o1, O_RUN);
      check("frz_lu_cnt1", lu1, 1);
      step();

      // Branch flush in the same cycle as a load-use hazard
      do_reset();
      lw(5'd8); step();
      alu(5'd8, 1, 5'd3, 1);
      br_taken = 1; settle();
      check("br_flush", o1, O_FLUSH);
      step();
      br_taken = 0; settle();
      check("br_no_stall", o1, O_RUN);
      check("br_lu_cnt", lu1, 0);
      step();

      // Saturation, clear, reset mid-stall on the CNT_W=2 instance
      do_reset();
      for (int i = 0; i < 5; i++) begin
         lw(5'd8); step();
         alu(5'd8, 1, 5'd0, 0); step();
      end
      check("sat_c2", lu3, 3);
      check("sat_l1_ref", lu1, 5);
      idle();
      cnt_clr = 1; step();
      cnt_clr = 0;
      check("clr_c2", lu3, 0);
      lw(5'd8); step();
      alu(5'd8, 1, 5'd0, 0); settle();
      check("c2_stall", o3, O_STALL);
      rst = 1; settle();
      check("c2_rst_outs", o3, O_RST);
      step();
      rst = 0; settle();
      check("c2_post_rst", o3, O_RUN);
      check("c2_post_rst_cnt", lu3, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time bound so the run can never hang
   initial begin
      #100000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1);
   end

endmodule
